// File: rtl/serdes_pkg.sv
// Shared serdes types and constants.
// Used by the PISO transmitter and its bit counter.
package serdes_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    localparam int DEF_WIDTH = 8;

    localparam bit BIT_MSB_FIRST = 1'b1;
    localparam bit BIT_LSB_FIRST = 1'b0;

endpackage

// File: rtl/bit_counter.sv
// Mod-WIDTH up counter with synchronous clear and terminal count.
// tc marks the last bit slot of a word.
module bit_counter
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input.
// Back-to-back words leave no idle gap on the serial side.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = BIT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             xfer;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign busy      = (state == S_SHIFT);
    assign din_ready = (state == S_IDLE) || (busy && tc);
    assign xfer      = din_valid && din_ready;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (xfer),
        .en    (busy && !tc),
        .cnt   (cnt),
        .tc    (tc)
    );

    // First bit goes straight to dout on load; shreg holds the remainder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        state       <= S_SHIFT;
                        shreg       <= advance(din);
                        dout        <= head(din);
                        dout_valid  <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        dout        <= 1'b0;
                        dout_valid  <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (cnt != CW'(WIDTH - 1)) begin
                        shreg       <= advance(shreg);
                        dout        <= head(shreg);
                        dout_valid  <= 1'b1;
                        frame_start <= 1'b0;
                    end else if (xfer) begin
                        shreg       <= advance(din);
                        dout        <= head(din);
                        dout_valid  <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        state       <= S_IDLE;
                        dout        <= 1'b0;
                        dout_valid  <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    dout        <= 1'b0;
                    dout_valid  <= 1'b0;
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer, MSB- and LSB-first instances.
// Loopback through a 3-stage delay line on the MSB instance.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] din_m = '0;
    logic       dv_m = 1'b0;
    logic       rdy_m, dout_m, dval_m, fs_m, busy_m;

    logic [7:0] din_l = '0;
    logic       dv_l = 1'b0;
    logic       rdy_l, dout_l, dval_l, fs_l, busy_l;

    int checks = 0;
    int errors = 0;

    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic       lb_q[$];
    logic       lb_en = 1'b0;

    logic       l1 = 0, l2 = 0, l3 = 0;
    logic       v1 = 0, v2 = 0, v3 = 0;

    int run_m = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .din         (din_m),
        .din_valid   (dv_m),
        .din_ready   (rdy_m),
        .dout        (dout_m),
        .dout_valid  (dval_m),
        .frame_start (fs_m),
        .busy        (busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .din         (din_l),
        .din_valid   (dv_l),
        .din_ready   (rdy_l),
        .dout        (dout_l),
        .dout_valid  (dval_l),
        .frame_start (fs_l),
        .busy        (busy_l)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit lsb, input logic [7:0] w);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = lsb ? w[i] : w[7-i];
            if (lsb) q_l.push_back({i == 0, b});
            else begin
                q_m.push_back({i == 0, b});
                if (lb_en) lb_q.push_back(b);
            end
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input bit lsb, input logic [7:0] w);
        int n = 0;
        if (lsb) begin din_l = w; dv_l = 1'b1; end
        else begin din_m = w; dv_m = 1'b1; end
        while (!(lsb ? rdy_l : rdy_m) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(n), 0);
        @(posedge clk);
        push_exp(lsb, w);
        #1;
        if (lsb) dv_l = 1'b0;
        else dv_m = 1'b0;
    endtask

    always @(posedge clk) begin
        l1 <= dout_m;
        v1 <= dval_m && lb_en;
        l2 <= l1; v2 <= v1;
        l3 <= l2; v3 <= v2;
    end

    logic [1:0] e;
    logic       eb;

    always @(negedge clk) begin
        if (dval_m) begin
            run_m++;
            if (run_m > max_run) max_run = run_m;
            if (q_m.size() == 0) chk("msb_extra_bit", {fs_m, dout_m}, 32'hff);
            else begin
                e = q_m.pop_front();
                chk("msb_bit", {fs_m, dout_m}, e);
            end
        end else begin
            run_m = 0;
            chk("msb_idle_out", {fs_m, dout_m}, 0);
        end
        if (dval_l) begin
            if (q_l.size() == 0) chk("lsb_extra_bit", {fs_l, dout_l}, 32'hff);
            else begin
                e = q_l.pop_front();
                chk("lsb_bit", {fs_l, dout_l}, e);
            end
        end else begin
            chk("lsb_idle_out", {fs_l, dout_l}, 0);
        end
        if (v3) begin
            if (lb_q.size() == 0) chk("loop_extra", l3, 32'hff);
            else begin
                eb = lb_q.pop_front();
                chk("loop_bit", l3, eb);
            end
        end
    end

    initial begin
        // T1: reset held with din_valid high
        din_m = 8'hAA;
        dv_m = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_dval", dval_m, 0);
            chk("rst_dout", dout_m, 0);
            chk("rst_busy", busy_m, 0);
            chk("rst_ready", rdy_m, 1);
        end
        dv_m = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_dval", dval_m, 0);

        // T2: MSB first
        send(1'b0, 8'hB4);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_busy", busy_m, 0);
        chk("t2_ready", rdy_m, 1);

        // T3: LSB first
        send(1'b1, 8'hB4);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_busy", busy_l, 0);

        // T4: back-to-back
        max_run = 0;
        send(1'b0, 8'hA5);
        din_m = 8'h3C;
        dv_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_ready", rdy_m, (i == 7) ? 1 : 0);
            if (i < 7) begin @(posedge clk); #1; end
        end
        @(posedge clk);
        push_exp(1'b0, 8'h3C);
        #1;
        dv_m = 1'b0;
        chk("t4_ready_busy", rdy_m, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("t4_run", max_run, 16);
        chk("t4_idle_ready", rdy_m, 1);

        // T5: reset mid-word
        send(1'b0, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b0;
        q_m.delete();
        #1;
        chk("t5_async_dout", dout_m, 0);
        chk("t5_async_dval", dval_m, 0);
        chk("t5_async_busy", busy_m, 0);
        chk("t5_async_ready", rdy_m, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_idle_after", dval_m, 0);
        send(1'b0, 8'h81);
        repeat (12) @(posedge clk);
        #1;
        chk("t5_queue", q_m.size(), 0);

        // T6: loopback over 100 random words
        lb_en = 1'b1;
        for (int k = 0; k < 100; k++)
            send(1'b0, 8'($urandom_range(0, 255)));
        repeat (14) @(posedge clk);
        #1;
        lb_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("end_q_msb", q_m.size(), 0);
        chk("end_q_lsb", q_l.size(), 0);
        chk("end_q_loop", lb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
